// File: rtl/rx_timer.sv
// rx_timer: receive-side bit timer. Synchronises the raw line, qualifies the
// start bit, then issues one mid-bit sample strobe per bit of a
// start + 8 data + stop frame. Flags frame completion and a low stop bit.
// Optional build macro RX_RESYNC_EN: line edges seen away from the sample
// point re-centre the bit counter so a drifting transmitter still gets
// sampled near mid-bit.
module rx_timer #(
    parameter int BIT_PERIOD   = 27,
    parameter int SAMPLE_POINT = 13,
    parameter int NUM_BITS     = 10,
    parameter int CNT_WIDTH    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    input  logic       clear_timer,
    output logic       sample_strobe,
    output logic       sample_data,
    output logic [3:0] bit_count,
    output logic       packet_done,
    output logic       framing_error,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START_CHK, RECEIVE} state_t;

    localparam logic [CNT_WIDTH-1:0] SP_C   = CNT_WIDTH'(SAMPLE_POINT);
    localparam logic [CNT_WIDTH-1:0] LAST_C = CNT_WIDTH'(BIT_PERIOD - 1);
    localparam logic [3:0]           NB_C   = 4'(NUM_BITS);

    state_t               state, state_d;
    logic [CNT_WIDTH-1:0] clk_cnt, cnt_d;
    logic [3:0]           bc_d;
    logic                 strobe_d, data_d, done_d, fe_d, busy_d;
    logic                 sync1, sync, prev;
    logic                 fall;

    assign fall = !sync && prev;

`ifdef RX_RESYNC_EN
    // Edges within +/-2 of the sample point are treated as jitter, not drift.
    localparam logic [CNT_WIDTH-1:0] WIN_LO_C =
        CNT_WIDTH'((SAMPLE_POINT >= 2) ? SAMPLE_POINT - 2 : 0);
    localparam logic [CNT_WIDTH-1:0] WIN_HI_C = CNT_WIDTH'(SAMPLE_POINT + 2);
    logic resync;
    assign resync = (sync != prev) && ((clk_cnt < WIN_LO_C) || (clk_cnt > WIN_HI_C));
`endif

    // Two-flop synchroniser plus previous-value register; all idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync  <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= serial_in;
            sync  <= sync1;
            prev  <= sync;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_count     <= '0;
            sample_strobe <= 1'b0;
            sample_data   <= 1'b0;
            packet_done   <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            clk_cnt       <= cnt_d;
            bit_count     <= bc_d;
            sample_strobe <= strobe_d;
            sample_data   <= data_d;
            packet_done   <= done_d;
            framing_error <= fe_d;
            busy          <= busy_d;
        end
    end

    // Next-state and next-output logic; clear_timer overrides everything.
    always_comb begin
        state_d  = state;
        cnt_d    = clk_cnt;
        bc_d     = bit_count;
        strobe_d = 1'b0;
        data_d   = sample_data;
        done_d   = 1'b0;
        fe_d     = 1'b0;
        busy_d   = busy;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_d = START_CHK;
                    cnt_d   = '0;
                    bc_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            START_CHK: begin
                // Counter keeps running into RECEIVE so bit 0 timing carries on.
                cnt_d = clk_cnt + 1'b1;
                if (clk_cnt == SP_C) begin
                    if (!sync) begin
                        state_d  = RECEIVE;
                        strobe_d = 1'b1;
                        data_d   = 1'b0;
                        bc_d     = 4'd1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            RECEIVE: begin
                cnt_d = (clk_cnt == LAST_C) ? '0 : clk_cnt + 1'b1;
`ifdef RX_RESYNC_EN
                if (resync) cnt_d = '0;
`endif
                if (packet_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (clk_cnt == SP_C) begin
                    strobe_d = 1'b1;
                    data_d   = sync;
                    bc_d     = bit_count + 1'b1;
                    if (bit_count + 1'b1 == NB_C) begin
                        done_d = 1'b1;
                        fe_d   = !sync;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_timer) begin
            state_d  = IDLE;
            cnt_d    = '0;
            bc_d     = '0;
            busy_d   = 1'b0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
            fe_d     = 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_timer.sv
// tb_rx_timer: directed bench for rx_timer. Drives frames cycle by cycle and
// checks strobe timing, sampled data, bit index and completion flags against
// hand-derived schedules (first strobe 17 cycles after the line is driven low:
// 2 synchroniser cycles + 15).
module tb_rx_timer;

    logic       clk = 1'b0;
    logic       rst, serial_in, clear_timer;
    logic       sample_strobe, sample_data, packet_done, framing_error, busy;
    logic [3:0] bit_count;

    int nvec = 0;
    int nerr = 0;
    int tot_strobe = 0;
    int tot_done = 0;

    rx_timer dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .clear_timer  (clear_timer),
        .sample_strobe(sample_strobe),
        .sample_data  (sample_data),
        .bit_count    (bit_count),
        .packet_done  (packet_done),
        .framing_error(framing_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobe"}, {31'd0, sample_strobe}, 0);
        chk({tag, "_data"},   {31'd0, sample_data},   0);
        chk({tag, "_bc"},     {28'd0, bit_count},     0);
        chk({tag, "_done"},   {31'd0, packet_done},   0);
        chk({tag, "_fe"},     {31'd0, framing_error}, 0);
        chk({tag, "_busy"},   {31'd0, busy},          0);
    endtask

    // bits[0] is the start bit, bits[9] the stop bit. Line returns high for 'tail' cycles.
    task automatic run_frame(input logic [9:0] bits, input int bp, input bit timing, input int tail);
        int   idx;
        int   ndone;
        logic e;
        idx   = 0;
        ndone = 0;
        for (int c = 0; c < 10 * bp + tail; c++) begin
            serial_in = (c < 10 * bp) ? bits[c / bp] : 1'b1;
            if (timing) begin
                e = (c >= 17) && ((c - 17) % bp == 0) && ((c - 17) / bp < 10);
                chk("strobe_time", {31'd0, sample_strobe}, {31'd0, e});
            end
            if (sample_strobe === 1'b1) begin
                if (idx < 10) begin
                    chk("sample_data", {31'd0, sample_data}, {31'd0, bits[idx]});
                    chk("bit_count",   {28'd0, bit_count}, idx + 1);
                    chk("done_flag",   {31'd0, packet_done}, (idx == 9) ? 1 : 0);
                    chk("fe_flag",     {31'd0, framing_error}, (idx == 9 && !bits[9]) ? 1 : 0);
                end
                idx++;
                tot_strobe++;
            end else begin
                chk("done_no_strobe", {30'd0, packet_done, framing_error}, 0);
            end
            if (packet_done === 1'b1) begin
                ndone++;
                tot_done++;
            end
            tick();
        end
        chk("strobe_count", idx, 10);
        chk("done_count", ndone, 1);
    endtask

    initial begin
        logic [9:0] a5;
        int         s0, d0;
        a5 = {1'b1, 8'hA5, 1'b0};

        // Reset
        rst = 1'b1; serial_in = 1'b1; clear_timer = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("idle_busy",   {31'd0, busy}, 0);
            chk("idle_strobe", {31'd0, sample_strobe}, 0);
        end

        // Clean frame 0xA5
        run_frame(a5, 27, 1'b1, 20);
        chk("bc_hold_idle", {28'd0, bit_count}, 10);
        chk("busy_after",   {31'd0, busy}, 0);

        // Glitch: 5 low cycles is a false start
        for (int c = 0; c < 40; c++) begin
            serial_in = (c < 5) ? 1'b0 : 1'b1;
            chk("glitch_strobe", {31'd0, sample_strobe}, 0);
            if (c == 3)  chk("glitch_busy_rise", {31'd0, busy}, 1);
            if (c == 16) chk("glitch_busy_hold", {31'd0, busy}, 1);
            if (c == 17) chk("glitch_busy_fall", {31'd0, busy}, 0);
            tick();
        end

        // Framing error: 0x3C with stop bit low
        run_frame({1'b0, 8'h3C, 1'b0}, 27, 1'b1, 20);

        // Abort with clear_timer one cycle after the 4th strobe
        for (int c = 0; c < 100; c++) begin
            serial_in   = a5[c / 27];
            clear_timer = (c == 99);
            if (c == 98) begin
                chk("abort_strobe4", {31'd0, sample_strobe}, 1);
                chk("abort_bc4",     {28'd0, bit_count}, 4);
            end
            tick();
        end
        clear_timer = 1'b0;
        serial_in   = 1'b1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_bc",   {28'd0, bit_count}, 0);
        for (int c = 0; c < 300; c++) begin
            chk("abort_no_strobe", {30'd0, sample_strobe, packet_done}, 0);
            tick();
        end

        // Async reset mid-frame, landing while a strobe is high
        for (int c = 0; c <= 44; c++) begin
            serial_in = a5[c / 27];
            if (c < 44) tick();
        end
        chk("prerst_strobe", {31'd0, sample_strobe}, 1);
        chk("prerst_data",   {31'd0, sample_data}, 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        tick();
        serial_in = 1'b1;
        #2 rst = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("post_rst_busy", {31'd0, busy}, 0);

        // Back-to-back frames, no idle gap
        s0 = tot_strobe; d0 = tot_done;
        run_frame(a5, 27, 1'b1, 0);
        run_frame(a5, 27, 1'b1, 20);
        chk("b2b_strobes", tot_strobe - s0, 20);
        chk("b2b_done",    tot_done - d0, 2);

        // Fast transmitter: 26 clocks per bit, 0xFF
        run_frame({1'b1, 8'hFF, 1'b0}, 26, 1'b0, 40);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
